// File: rtl/codon_matcher.sv
// codon_matcher: matches user key nibbles against five reader codons
// in parallel; reports match id, no-match or timeout.
module codon_matcher #(
  parameter int MAX_LEN        = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done_reader,
  input  logic [3:0] codon1,
  input  logic [3:0] codon2,
  input  logic [3:0] codon3,
  input  logic [3:0] codon4,
  input  logic [3:0] codon5,
  input  logic [4:0] end_of_codon,
  output logic [2:0] codon_index,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic       ready,
  output logic       result_valid,
  output logic       match,
  output logic [2:0] match_id,
  output logic       timeout
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] LAST_IDX = 3'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    WAIT_CODONS,
    IDLE,
    COLLECT,
    RESULT
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [2:0]     r_idx;
  logic [2:0]     w_idx_nx;
  logic [4:0]     r_alive;
  logic [4:0]     w_alive_nx;
  logic [TW-1:0]  r_timer;
  logic [TW-1:0]  w_timer_nx;
  logic           r_match;
  logic           w_match_nx;
  logic [2:0]     r_match_id;
  logic [2:0]     w_match_id_nx;
  logic           r_timeout;
  logic           w_timeout_nx;

  logic [3:0]     w_codon [5];
  logic [4:0]     w_nonempty;
  logic [4:0]     w_alive;
  logic [4:0]     w_hit;
  logic [4:0]     w_last;
  logic [4:0]     w_done;
  logic [2:0]     w_first;

  assign w_codon[0] = codon1;
  assign w_codon[1] = codon2;
  assign w_codon[2] = codon3;
  assign w_codon[3] = codon4;
  assign w_codon[4] = codon5;

  // In IDLE the mask comes straight from the index-0 nibbles
  always_comb begin
    w_nonempty = '0;
    w_hit      = '0;
    for (int n = 0; n < 5; n++) begin
      w_nonempty[n] = (w_codon[n] != 4'hF);
    end
    w_alive = (r_state == IDLE) ? w_nonempty : r_alive;
    for (int n = 0; n < 5; n++) begin
      w_hit[n] = w_alive[n] & (w_codon[n] == key_value);
    end
  end

  assign w_last = end_of_codon | {5{r_idx == LAST_IDX}};
  assign w_done = w_hit & w_last;

  always_comb begin
    w_first = '0;
    for (int n = 4; n >= 0; n--) begin
      if (w_done[n]) w_first = 3'(n + 1);
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_idx_nx      = r_idx;
    w_alive_nx    = r_alive;
    w_timer_nx    = r_timer;
    w_match_nx    = r_match;
    w_match_id_nx = r_match_id;
    w_timeout_nx  = r_timeout;
    unique case (r_state)
      WAIT_CODONS: begin
        if (done_reader) w_state_nx = IDLE;
      end
      IDLE, COLLECT: begin
        if (key_valid) begin
          w_timer_nx = '0;
          if (|w_done) begin
            w_match_nx    = 1'b1;
            w_match_id_nx = w_first;
            w_timeout_nx  = 1'b0;
            w_state_nx    = RESULT;
          end else if (w_hit == '0) begin
            w_match_nx    = 1'b0;
            w_match_id_nx = '0;
            w_timeout_nx  = 1'b0;
            w_state_nx    = RESULT;
          end else begin
            w_alive_nx = w_hit & ~w_last;
            w_idx_nx   = r_idx + 3'd1;
            w_state_nx = COLLECT;
          end
        end else if (r_state == COLLECT) begin
          if (r_timer == TW'(TIMEOUT_CYCLES)) begin
            w_match_nx    = 1'b0;
            w_match_id_nx = '0;
            w_timeout_nx  = 1'b1;
            w_state_nx    = RESULT;
          end else begin
            w_timer_nx = r_timer + TW'(1);
          end
        end
      end
      RESULT: begin
        w_idx_nx   = '0;
        w_alive_nx = '1;
        w_timer_nx = '0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = WAIT_CODONS;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= WAIT_CODONS;
      r_idx      <= '0;
      r_alive    <= '1;
      r_timer    <= '0;
      r_match    <= 1'b0;
      r_match_id <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_alive    <= w_alive_nx;
      r_timer    <= w_timer_nx;
      r_match    <= w_match_nx;
      r_match_id <= w_match_id_nx;
      r_timeout  <= w_timeout_nx;
    end
  end

  assign codon_index  = r_idx;
  assign ready        = (r_state == IDLE) | (r_state == COLLECT);
  assign result_valid = (r_state == RESULT);
  assign match        = r_match;
  assign match_id     = r_match_id;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_codon_matcher.sv
// tb_codon_matcher: directed vectors against codon_matcher with a
// behavioural codon reader driving the nibble/end inputs.
module tb_codon_matcher;

  logic       clock = 1'b0;
  logic       reset;
  logic       done_reader;
  logic [3:0] codon1, codon2, codon3, codon4, codon5;
  logic [4:0] end_of_codon;
  logic [2:0] codon_index;
  logic       key_valid;
  logic [3:0] key_value;
  logic       ready;
  logic       result_valid;
  logic       match;
  logic [2:0] match_id;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] mem [5][6];
  logic [3:0] rd_nib [5];
  int         rd_i;

  always #5 clock = ~clock;

  codon_matcher #(.MAX_LEN(6), .TIMEOUT_CYCLES(20)) dut (
    .clock        (clock),
    .reset        (reset),
    .done_reader  (done_reader),
    .codon1       (codon1),
    .codon2       (codon2),
    .codon3       (codon3),
    .codon4       (codon4),
    .codon5       (codon5),
    .end_of_codon (end_of_codon),
    .codon_index  (codon_index),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .ready        (ready),
    .result_valid (result_valid),
    .match        (match),
    .match_id     (match_id),
    .timeout      (timeout)
  );

  // reader model: end flag is left low at the final index
  always_comb begin
    rd_i = (codon_index > 3'd5) ? 5 : int'(codon_index);
    end_of_codon = '0;
    for (int n = 0; n < 5; n++) begin
      rd_nib[n] = mem[n][rd_i];
      if (rd_i < 5) end_of_codon[n] = (mem[n][rd_i+1] == 4'hF);
    end
  end

  assign codon1 = rd_nib[0];
  assign codon2 = rd_nib[1];
  assign codon3 = rd_nib[2];
  assign codon4 = rd_nib[3];
  assign codon5 = rd_nib[4];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int n = 0; n < 5; n++)
      for (int i = 0; i < 6; i++)
        mem[n][i] = 4'hF;
  endtask

  task automatic load_a(input logic [3:0] c2b);
    clear_mem();
    mem[0][0] = 4'h3; mem[0][1] = 4'h7; mem[0][2] = 4'hA;
    mem[1][0] = 4'h3; mem[1][1] = c2b;
    mem[2][0] = 4'h5;
  endtask

  task automatic key(input logic [3:0] v);
    @(negedge clock);
    key_valid = 1'b1;
    key_value = v;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    reset       = 1'b0;
    done_reader = 1'b0;
    key_valid   = 1'b0;
    key_value   = 4'h0;
    load_a(4'h7);
    #1;
    check("rst_ready", ready, 0);
    check("rst_rv", result_valid, 0);
    check("rst_idx", codon_index, 0);
    check("rst_match", match, 0);
    check("rst_id", match_id, 0);
    check("rst_to", timeout, 0);

    @(negedge clock);
    reset = 1'b1;
    idle(2);
    check("wait_ready", ready, 0);
    key(4'h5);
    check("wait_drop_rv", result_valid, 0);
    check("wait_drop_match", match, 0);
    done_reader = 1'b1;
    idle(1);
    check("idle_ready", ready, 1);

    // 3,7: c2 ends before c1
    key(4'h3);
    check("a_idx1", codon_index, 1);
    check("a_rv0", result_valid, 0);
    key(4'h7);
    check("a_rv", result_valid, 1);
    check("a_match", match, 1);
    check("a_id", match_id, 2);
    check("a_ready", ready, 0);
    idle(1);
    check("a_rv_off", result_valid, 0);
    check("a_idx0", codon_index, 0);

    key(4'h5);
    check("b_rv", result_valid, 1);
    check("b_id", match_id, 3);
    idle(1);
    check("b_idx0", codon_index, 0);

    // no match, then a key during RESULT is dropped
    key(4'h3);
    key(4'h8);
    check("c_rv", result_valid, 1);
    check("c_match", match, 0);
    check("c_id", match_id, 0);
    check("c_ready", ready, 0);
    key_valid = 1'b1;
    key_value = 4'h5;
    @(negedge clock);
    key_valid = 1'b0;
    check("c_drop_rv", result_valid, 0);
    check("c_drop_match", match, 0);
    idle(1);
    check("c_drop_rv2", result_valid, 0);

    // full-length codon terminated by the forced end
    clear_mem();
    for (int i = 0; i < 6; i++) mem[0][i] = 4'(i + 1);
    for (int i = 0; i < 5; i++) key(4'(i + 1));
    check("d_idx5", codon_index, 5);
    check("d_rv0", result_valid, 0);
    key(4'h6);
    check("d_rv", result_valid, 1);
    check("d_match", match, 1);
    check("d_id", match_id, 1);

    // timeout at exactly 20 idle cycles
    load_a(4'h8);
    key(4'h3);
    idle(20);
    check("e_pre_rv", result_valid, 0);
    check("e_pre_to", timeout, 0);
    idle(1);
    check("e_rv", result_valid, 1);
    check("e_to", timeout, 1);
    check("e_match", match, 0);
    check("e_id", match_id, 0);
    idle(1);
    check("e_rv_off", result_valid, 0);

    // key on the expiry cycle beats the timeout
    key(4'h3);
    idle(19);
    key(4'h7);
    check("f_idx2", codon_index, 2);
    check("f_rv0", result_valid, 0);
    key(4'hA);
    check("f_rv", result_valid, 1);
    check("f_id", match_id, 1);
    check("f_to", timeout, 0);
    idle(1);

    // async reset mid-entry
    key(4'h3);
    check("g_idx1", codon_index, 1);
    #2;
    reset = 1'b0;
    done_reader = 1'b0;
    #1;
    check("g_idx", codon_index, 0);
    check("g_ready", ready, 0);
    check("g_match", match, 0);
    check("g_id", match_id, 0);
    check("g_rv", result_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    key(4'h3);
    check("g_wait_ready", ready, 0);
    check("g_wait_idx", codon_index, 0);
    done_reader = 1'b1;
    idle(1);
    check("g_ready_on", ready, 1);
    key(4'h3);
    key(4'h8);
    check("g_rv_res", result_valid, 1);
    check("g_id_res", match_id, 2);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
